// File: rtl/pattern_detect_param.sv
// pattern_detect_param
//   Parametrised serial pattern detector. One bit is accepted per cycle while
//   x_valid is high and compared against a runtime-loadable PAT_W-bit pattern
//   (MSB = first-received bit). Supports overlapping and non-overlapping
//   detection, and keeps a saturating count of matches.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   x          serial data bit
//   x_valid    x is sampled only when high
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   load pat_in into the pattern register (clears history)
//   pat_in     new pattern, MSB first
//   cnt_clr    synchronous clear of match_cnt / cnt_sat (wins over a hit)
//   z          registered single-cycle match pulse
//   match_cnt  saturating match count
//   cnt_sat    sticky, set once match_cnt reaches all-ones
module pattern_detect_param #(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PATTERN = 4'b0110,
  parameter int unsigned           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  candidate;
  logic              full;
  logic              hit;
  logic [CNT_W-1:0]  cnt_inc;

  // fill saturates at PAT_W-1: once that many bits are held, the incoming
  // bit completes a full PAT_W-bit window.
  always_comb begin
    candidate = {hist[PAT_W-2:0], x};
    full      = (fill == FILL_MAX);
    hit       = x_valid && !pat_load && full && (candidate == pat);
    cnt_inc   = match_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (pat_load) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (x_valid) begin
      hist <= candidate;
      z    <= hit;
      if (hit && !overlap)
        fill <= '0;
      else if (!full)
        fill <= fill + FILL_W'(1);
    end else begin
      z <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= cnt_inc;
      if (cnt_inc == '1)
        cnt_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_detect_param.sv
module tb_pattern_detect_param;

  logic       clk;
  logic       rst;
  logic       x;
  logic       x_valid;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic [7:0] pat_in8;
  logic       cnt_clr;

  logic       z4, sat4, zs, sats, z8, sat8;
  logic [7:0] cnt4, cnt8;
  logic [1:0] cnts;

  int n_cmp = 0;
  int n_err = 0;

  pattern_detect_param #(.PAT_W(4), .PATTERN(4'b0110), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z4), .match_cnt(cnt4), .cnt_sat(sat4)
  );

  pattern_detect_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(zs), .match_cnt(cnts), .cnt_sat(sats)
  );

  pattern_detect_param #(.PAT_W(8), .PATTERN(8'hA5), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in8), .cnt_clr(cnt_clr),
    .z(z8), .match_cnt(cnt8), .cnt_sat(sat8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 time unit after
  // the following rising edge so registered outputs can be sampled.
  task automatic drive(input logic xv, input logic xb, input logic ld, input logic clr);
    @(negedge clk);
    x_valid  = xv;
    x        = xb;
    pat_load = ld;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    x_valid  = 1'b0;
    x        = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [19:0] s20;
  logic [6:0]  s7;
  logic [15:0] s16;

  initial begin
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; cnt_clr = 1'b0; pat_in = 4'b1011; pat_in8 = 8'hA5;
    s20 = 20'b0011_0100_0110_1100_1111;
    s7  = 7'b1011011;

    // Reset state
    #12;
    chk("rst_z4", z4, 0);       chk("rst_cnt4", cnt4, 0); chk("rst_sat4", sat4, 0);
    chk("rst_zs", zs, 0);       chk("rst_cnts", cnts, 0);
    chk("rst_z8", z8, 0);       chk("rst_cnt8", cnt8, 0);
    @(negedge clk);
    rst = 1'b1;

    // Default 0110, overlapping
    overlap = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, s20[19-i], 1'b0, 1'b0);
      chk($sformatf("ov1_z%0d", i), z4, (i == 4 || i == 11 || i == 14));
    end
    chk("ov1_cnt", cnt4, 3);

    // Same stream, non-overlapping
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, s20[19-i], 1'b0, 1'b0);
      chk($sformatf("ov0_z%0d", i), z4, (i == 4 || i == 11));
    end
    chk("ov0_cnt", cnt4, 2);

    // Pattern load; a load with x_valid high must not shift x in
    do_reset();
    overlap = 1'b1;
    pat_in  = 4'b1011;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ld_x_z", z4, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0); chk("ld_x_b0", z4, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("ld_x_b1", z4, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); chk("ld_x_b2", z4, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s7[6-i], 1'b0, 1'b0);
      chk($sformatf("ld1_z%0d", i), z4, (i == 3 || i == 6));
    end
    chk("ld1_cnt", cnt4, 2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ld_clears_z", z4, 0);
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s7[6-i], 1'b0, 1'b0);
      chk($sformatf("ld0_z%0d", i), z4, (i == 3));
    end
    chk("ld0_cnt", cnt4, 3);

    // Valid gaps keep history
    do_reset();
    overlap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("gap_idle%0d", i), z4, 0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("gap_hit", z4, 1);
    chk("gap_cnt", cnt4, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("gap_pulse_end", z4, 0);

    // Reset mid-sequence discards history
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0;
    #2;
    chk("midrst_z", z4, 0);
    chk("midrst_cnt", cnt4, 0);
    chk("midrst_sat", sat4, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_nohit", z4, 0);

    // Saturation and clear on the CNT_W=2 / 1111 instance
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("sat_z%0d", i), zs, (i >= 3));
      chk($sformatf("sat_cnt%0d", i), cnts, (i >= 3) ? i - 2 : 0);
    end
    chk("sat_flag", sats, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_hold_z", zs, 1);
    chk("sat_hold_cnt", cnts, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_z", zs, 1);
    chk("clr_cnt", cnts, 0);
    chk("clr_sat", sats, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_clr_cnt", cnts, 1);
    chk("post_clr_sat", sats, 0);

    // PAT_W=8, pattern A5
    do_reset();
    overlap = 1'b1;
    s16 = 16'hA5A5;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, s16[15-i], 1'b0, 1'b0);
      chk($sformatf("a5_z%0d", i), z8, (i == 7 || i == 15));
    end
    chk("a5_cnt", cnt8, 2);
    do_reset();
    s16 = 16'hA5A4;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, s16[15-i], 1'b0, 1'b0);
      chk($sformatf("a5err_z%0d", i), z8, (i == 7));
    end
    chk("a5err_cnt", cnt8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_detect_param.md
# pattern_detect_param

Parametrised serial pattern detector, the next generation of the fixed 0110 detector in the FSM library. It accepts one bit per cycle when valid and matches against a runtime-loadable pattern of PAT_W bits. Overlapping and non-overlapping detection are both supported, and a saturating match counter is included. It sits between a serial bit source and control logic that consumes single-cycle match pulses.

## Interface
- PAT_W, 4: pattern length in bits, 2..32.
- PATTERN, 4'b0110: pattern register value after reset. The MSB is the first-received bit.
- CNT_W, 8: match counter width, ≥2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  in  1  load pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB is the first bit.
- cnt_clr  in  1  synchronous clear of match_cnt and cnt_sat.
- z  out  1  registered match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- cnt_sat  out  1  sticky; set when match_cnt reaches all-ones.

## Operation
- State registers:
  - pat[PAT_W-1:0]: the pattern.
  - hist[PAT_W-1:0]: bit history, newest bit at the LSB.
  - fill: valid-history count, 0..PAT_W-1, saturating.
  - z, match_cnt, cnt_sat.
- On reset (rst low, asynchronous): pat=PATTERN, hist=0, fill=0, z=0, match_cnt=0, cnt_sat=0.
- Per-edge priority, highest first:
  1. pat_load=1: pat←pat_in, hist←0, fill←0, z←0. x is ignored that cycle even if x_valid=1.
  2. x_valid=1:
     - Candidate is {hist[PAT_W-2:0], x}.
     - hit = (fill ≥ PAT_W-1) && (candidate == pat).
     - hist←candidate; z←hit.
     - If hit and overlap=0: fill←0.
     - Otherwise: fill←min(fill+1, PAT_W-1).
  3. x_valid=0: hist and fill hold; z←0.
- Counter:
  - cnt_clr=1: match_cnt←0 and cnt_sat←0. Clear wins over a same-cycle hit.
  - Else, on hit: if match_cnt ≠ all-ones, match_cnt←match_cnt+1. Then cnt_sat←1 if the resulting value is all-ones.
  - At all-ones, further hits leave match_cnt unchanged and z still pulses.
- overlap is sampled on every hit. A change affects only subsequent hits.
- Gaps in x_valid do not break a sequence; the history persists across invalid cycles.
- The pattern is compared literally. No wildcard or don't-care bits.

## Timing
- z is registered: it is high for exactly the one cycle after the edge that samples the completing bit. Latency is 1 cycle from the last bit to z.
- match_cnt and cnt_sat update on the same edge as z.
- A match requires PAT_W valid bits since the last reset, pattern load, or non-overlap hit.
- Back-to-back hits (overlap=1, e.g. pattern 1111 on a stream of ones) give z high on consecutive cycles.
- Reset mid-sequence discards the partial history. At least PAT_W new valid bits are needed before the next match.
- No combinational path from any input to any output.

## Test plan
- **Default 0110, overlap=1.** Reset, release rst. Drive x_valid=1 with the stream 0011 0100 0110 1100 1111.
  - z pulses after bits 4, 11 and 14 (0-indexed).
  - match_cnt=3.
- **Same stream, overlap=0.** z pulses after bits 4 and 11 only; match_cnt=2. Bit 11 is not reused.
- **Pattern load.** pat_load with pat_in=1011, then stream 1011011.
  - overlap=1: z after bits 3 and 6, count 2.
  - overlap=0: z after bit 3 only, count 1.
  - pat_load asserted together with x_valid: that bit is not shifted in.
- **Valid gaps and reset mid-sequence.**
  - 0,1,1 with x_valid=1, three idle cycles, then 0: one z pulse.
  - Separately, 0,1,1, then rst low for 1 cycle, then 0: no pulse.
  - Check all outputs are 0 during reset.
- **Saturation and clear (CNT_W=2, pattern 1111, overlap=1).** Six consecutive 1s.
  - z is high for 3 consecutive cycles; match_cnt stops at 3; cnt_sat=1.
  - cnt_clr asserted on a hit cycle: count=0 and cnt_sat=0.
- **PAT_W=8, PATTERN=8'hA5.** Stream 0xA5A5, MSB first, overlap=1.
  - Hits after bits 7 and 15 only (shifts of 2, 4 and 6 do not match).
  - A single-bit error in the second byte suppresses its hit.
